// File: rtl/serial_operand_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : project_pkg
// Description : Shared constants, receive FSM state encoding and a small
//               width helper used by the serial operand receiver slice.
// Revision    : 1.0 - initial release
// ============================================================================
package project_pkg;

    // Default operand word width and words per operand frame.
    localparam int OPERAND_WIDTH       = 32;
    localparam int DEFAULT_FRAME_WORDS = 2;

    // Receive-side states: collecting serial bits, or stalled on a full FIFO.
    typedef enum logic [0:0] {
        RX_COLLECT = 1'b0,
        RX_STALL   = 1'b1
    } rx_state_t;

    // $clog2 that never yields a zero-width vector (for values of 1).
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_operand_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_operand_receiver_if
// Description : Bundles the serial input side and the word output side of the
//               receiver.
//               in / ready                 : bit-serial input handshake
//               word_data / word_valid /
//               word_last / word_ready     : word stream to the compute core
//               frame_done                 : pulse after a frame's last word
//               bit_count                  : bits held in the partial word
//               Modport slave is the receiver; master is the stimulus/core.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_operand_receiver_if
    import project_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH
);
    localparam int BC_W = clog2_min1(WIDTH);

    logic             in;
    logic             ready;
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_last;
    logic             word_ready;
    logic             frame_done;
    logic [BC_W-1:0]  bit_count;

    modport slave (
        input  in,
        input  word_ready,
        output ready,
        output word_data,
        output word_valid,
        output word_last,
        output frame_done,
        output bit_count
    );

    modport master (
        output in,
        output word_ready,
        input  ready,
        input  word_data,
        input  word_valid,
        input  word_last,
        input  frame_done,
        input  bit_count
    );

endinterface
`default_nettype wire

// File: rtl/serial_operand_receiver_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ft
// Description : Fall-through synchronous FIFO. The head entry is visible on
//               pop_data whenever the FIFO is non-empty (zero when empty).
//               Ports: clk, rst (async, active-high), push/push_data,
//               pop/pop_data, count, full, empty.
//               Pushes while full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ft #(
    parameter  int DATA_W = 33,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] push_data,
    input  wire logic              pop,
    output logic      [DATA_W-1:0] pop_data,
    output logic      [CNT_W-1:0]  count,
    output logic                   full,
    output logic                   empty
);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == C_DEPTH);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Gate the head so stale storage never leaks out while empty.
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_operand_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_operand_receiver
// Description : Deserializes a bit-serial operand stream into WIDTH-bit words,
//               tags the last word of each FRAME_WORDS-word frame, buffers
//               words in a fall-through FIFO and presents them over a
//               valid/ready interface.
//               Ports: clk, rst (async, active-high), bus (slave modport of
//               serial_operand_receiver_if: in, ready, word_data, word_valid,
//               word_last, word_ready, frame_done, bit_count).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_operand_receiver
    import project_pkg::*;
#(
    parameter int WIDTH       = OPERAND_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    serial_operand_receiver_if.slave bus
);
    localparam int BC_W  = clog2_min1(WIDTH);
    localparam int IDX_W = clog2_min1(FRAME_WORDS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_COLLECT = RX_COLLECT;
    localparam logic [0:0] ST_STALL   = RX_STALL;

    localparam logic [BC_W-1:0]  C_LAST_BIT  = BC_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] C_ONE_SHORT = CNT_W'(FIFO_DEPTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_assembled;
    logic [BC_W-1:0]  r_bit_count;
    logic [IDX_W-1:0] r_word_idx;
    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic             r_frame_done;

    logic             w_ready;
    logic             w_word_end;
    logic             w_last_tag;
    logic             w_pop;
    logic [WIDTH:0]   w_push_data;
    logic [WIDTH:0]   w_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    // ------------------------------------------------------------------
    // Bit assembly: the word as it stands including the bit on `in`.
    // ------------------------------------------------------------------
    generate
        if (WIDTH == 1) begin : g_single
            assign w_assembled = bus.in;
        end else if (MSB_FIRST) begin : g_msb
            assign w_assembled = {r_shift[WIDTH-2:0], bus.in};
        end else begin : g_lsb
            assign w_assembled = {bus.in, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // Stalled exactly when the FIFO is full, so ready equals count != DEPTH
    // while coming straight from a register.
    assign w_ready     = (r_state == ST_COLLECT);
    assign w_word_end  = w_ready && (r_bit_count == C_LAST_BIT);
    assign w_last_tag  = (r_word_idx == C_LAST_IDX);
    assign w_push_data = {w_last_tag, w_assembled};
    assign w_pop       = !w_fifo_empty && bus.word_ready;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (w_word_end && !w_pop && (w_fifo_count == C_ONE_SHORT)) begin
                    w_state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                // The not-full term only matters for recovery from an
                // inconsistent state; in normal operation a pop releases it.
                if (w_pop || !w_fifo_full) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Deserializer, frame position and frame_done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            r_bit_count  <= '0;
            r_word_idx   <= '0;
            r_state      <= ST_COLLECT;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_pop && w_head[WIDTH];
            if (w_ready) begin
                if (w_word_end) begin
                    r_shift     <= '0;
                    r_bit_count <= '0;
                    r_word_idx  <= w_last_tag ? '0 : r_word_idx + IDX_W'(1);
                end else begin
                    r_shift     <= w_assembled;
                    r_bit_count <= r_bit_count + BC_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Word buffer: data plus last tag in the top bit
    // ------------------------------------------------------------------
    sync_fifo_ft #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_word_end),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign bus.ready      = w_ready;
    assign bus.word_data  = w_head[WIDTH-1:0];
    assign bus.word_last  = w_head[WIDTH];
    assign bus.word_valid = !w_fifo_empty;
    assign bus.frame_done = r_frame_done;
    assign bus.bit_count  = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_operand_receiver
// Description : Self-checking bench for serial_operand_receiver. dut0 is the
//               MSB-first receiver; dut1 is an LSB-first instance.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_operand_receiver;
    import project_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } sb_t;

    typedef struct {
        logic [W-1:0] data;
        logic         exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rst1;

    always #5 clk = ~clk;

    serial_operand_receiver_if #(.WIDTH(W)) bus0 ();
    serial_operand_receiver_if #(.WIDTH(W)) bus1 ();

    serial_operand_receiver #(
        .WIDTH(W), .FIFO_DEPTH(4), .FRAME_WORDS(2), .MSB_FIRST(1'b1)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    serial_operand_receiver #(
        .WIDTH(W), .FIFO_DEPTH(4), .FRAME_WORDS(2), .MSB_FIRST(1'b0)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    logic [W-1:0] m_sr;
    int   m_bits;
    int   m_idx;
    logic exp_fd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic model_reset();
        sb.delete();
        m_sr   = '0;
        m_bits = 0;
        m_idx  = 0;
    endtask

    // One clock of stimulus on dut0; returns whether the bit was accepted.
    task automatic drive_cycle(input logic b, input logic wr, output logic acc);
        sb_t e;
        @(negedge clk);
        bus0.in         = b;
        bus0.word_ready = wr;
        #1;
        acc = bus0.ready;
        @(posedge clk);
        if (acc) begin
            m_sr = {m_sr[W-2:0], b};
            m_bits++;
            if (m_bits == W) begin
                e.data = m_sr;
                e.last = (m_idx == 1);
                sb.push_back(e);
                m_idx  = (m_idx + 1) % 2;
                m_bits = 0;
                m_sr   = '0;
            end
        end
    endtask

    // Sends a word MSB first; pop_last raises word_ready on the final bit only.
    task automatic send_word(input logic [W-1:0] d, input logic wr, input logic pop_last);
        logic acc;
        int   tries;
        for (int i = 0; i < W; i++) begin
            tries = 0;
            do begin
                drive_cycle(d[W-1-i], (pop_last && i == W - 1) ? 1'b1 : wr, acc);
                tries++;
            end while (!acc && tries < 100);
            if (!acc) fail_now("send_word_stall");
        end
    endtask

    // Scoreboard monitor: every pop is compared in order; frame_done follows.
    initial begin
        sb_t e;
        exp_fd = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_fd = 1'b0;
            end else begin
                chk("frame_done", bus0.frame_done, exp_fd);
                exp_fd = 1'b0;
                if (bus0.word_valid && bus0.word_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("pop_without_expected_word");
                    end else begin
                        e = sb.pop_front();
                        chk("pop_data", bus0.word_data, e.data);
                        chk("pop_last", bus0.word_last, e.last);
                        exp_fd = e.last;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic acc;
        int   acc_cnt;
        int   full_seen;
        logic [W-1:0] lw;

        vecs[0] = '{data: 32'h0000000A, exp_last: 1'b1};
        vecs[1] = '{data: 32'h12345678, exp_last: 1'b0};
        vecs[2] = '{data: 32'hCAFEF00D, exp_last: 1'b1};
        vecs[3] = '{data: 32'h0F0F0F0F, exp_last: 1'b0};
        vecs[4] = '{data: 32'hFFFFFFFF, exp_last: 1'b1};
        vecs[5] = '{data: 32'h00000000, exp_last: 1'b0};

        rst  = 1'b1;
        rst1 = 1'b1;
        bus0.in = 1'b0;  bus0.word_ready = 1'b0;
        bus1.in = 1'b0;  bus1.word_ready = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_word_valid", bus0.word_valid, 0);
        chk("rst_word_data", bus0.word_data, 0);
        chk("rst_word_last", bus0.word_last, 0);
        chk("rst_frame_done", bus0.frame_done, 0);
        chk("rst_bit_count", bus0.bit_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ready_after_rst", bus0.ready, 1);

        // Test 1: 0x00000005 MSB first, core not ready
        lw = 32'h00000005;
        for (int i = 0; i < W - 1; i++) drive_cycle(lw[W-1-i], 1'b0, acc);
        #1;
        chk("t1_valid_before_last_bit", bus0.word_valid, 0);
        chk("t1_bit_count_31", bus0.bit_count, 31);
        drive_cycle(lw[0], 1'b0, acc);
        #1;
        chk("t1_valid", bus0.word_valid, 1);
        chk("t1_data", bus0.word_data, 32'h00000005);
        chk("t1_last", bus0.word_last, 0);
        chk("t1_bit_count", bus0.bit_count, 0);

        // Test 2: table of words with the core ready; each word is alone at
        // the head when it completes because the previous one pops at once.
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].data, 1'b1, 1'b0);
            #1;
            chk("tbl_valid", bus0.word_valid, 1);
            chk("tbl_data", bus0.word_data, vecs[v].data);
            chk("tbl_last", bus0.word_last, vecs[v].exp_last);
        end

        // Test 3: fill the FIFO with word_ready low
        acc_cnt   = 0;
        full_seen = 0;
        for (int c = 0; c < 140; c++) begin
            drive_cycle(1'($urandom_range(0, 1)), (c == 0) ? 1'b1 : 1'b0, acc);
            if (acc) acc_cnt++;
            if (acc && acc_cnt == 4 * W) begin
                #1;
                chk("t3_ready_low_when_full", bus0.ready, 0);
                full_seen = 1;
            end
        end
        chk("t3_accepted_bits", acc_cnt, 4 * W);
        chk("t3_full_seen", full_seen, 1);
        chk("t3_bit_count_held", bus0.bit_count, 0);
        drive_cycle(1'b1, 1'b1, acc);
        chk("t3_bit_held_off", acc, 0);
        #1;
        chk("t3_ready_after_pop", bus0.ready, 1);
        send_word($urandom, 1'b1, 1'b0);
        send_word($urandom, 1'b1, 1'b0);

        // Test 4: hold two words, then push and pop on the same edge 16 times
        send_word($urandom, 1'b0, 1'b0);
        #1;
        chk("t4_count_start", dut0.u_fifo.count, 2);
        for (int k = 0; k < 16; k++) begin
            send_word($urandom, 1'b0, 1'b1);
            #1;
            chk("t4_count_steady", dut0.u_fifo.count, 2);
        end

        // Test 5: reset mid-word with two words buffered
        lw = $urandom;
        for (int i = 0; i < 17; i++) drive_cycle(lw[W-1-i], 1'b0, acc);
        #1;
        chk("t5_bit_count_17", bus0.bit_count, 17);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", bus0.word_valid, 0);
        chk("t5_async_data", bus0.word_data, 0);
        chk("t5_async_last", bus0.word_last, 0);
        chk("t5_async_bit_count", bus0.bit_count, 0);
        chk("t5_async_frame_done", bus0.frame_done, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_ready", bus0.ready, 1);
        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        #1;
        chk("t5_data", bus0.word_data, 32'hDEADBEEF);
        chk("t5_last", bus0.word_last, 0);
        send_word($urandom, 1'b1, 1'b0);
        send_word($urandom, 1'b1, 1'b0);

        // Test 6: LSB-first instance
        rst = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        lw = 32'h80000001;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bus1.in = lw[i];
            @(posedge clk);
        end
        #1;
        chk("t6_valid", bus1.word_valid, 1);
        chk("t6_data_80000001", bus1.word_data, 32'h80000001);
        lw = 32'h12345678;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bus1.in         = lw[i];
            bus1.word_ready = (i == 0);
            @(posedge clk);
        end
        #1;
        chk("t6_data_12345678", bus1.word_data, 32'h12345678);
        chk("t6_last", bus1.word_last, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
